// File: rtl/alu_result_collector.sv
// alu_result_collector: assembles two 4-lane ALU phases into an 8-lane vector and queues it for writeback
module alu_result_collector #(
  parameter int LANE_W = 8,
  parameter int REG_AW = 4,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_start,
  input  logic [REG_AW-1:0]   dest_addr,
  input  logic                out_en1,
  input  logic                out_en2,
  input  logic                alu_rdy,
  input  logic [4*LANE_W-1:0] lane_result,
  output logic                start_ok,
  output logic                wb_valid,
  output logic [REG_AW-1:0]   wb_addr,
  output logic [8*LANE_W-1:0] wb_data,
  input  logic                wb_ready,
  output logic                seq_err
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, WAIT_P1, WAIT_P2, WAIT_RDY} state_t;
  state_t              state_q, state_d;
  logic [REG_AW-1:0]   addr_q, addr_d;
  logic [4*LANE_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic                err_q, err_d;
  logic [REG_AW-1:0]   maddr_q [DEPTH];
  logic [8*LANE_W-1:0] mdata_q [DEPTH];
  logic [PW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q;
  logic                multi, push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign start_ok = state_q == IDLE && cnt_q < CW'(DEPTH);
  assign multi    = (out_en1 & out_en2) | (out_en1 & alu_rdy) | (out_en2 & alu_rdy);
  assign push     = state_q == WAIT_RDY && alu_rdy && !multi;
  assign wb_valid = cnt_q != '0;
  assign pop      = wb_valid & wb_ready;
  assign wb_addr  = maddr_q[rd_q];
  assign wb_data  = mdata_q[rd_q];
  assign seq_err  = err_q;
  // Sequencing FSM: advance one phase per valid strobe, flag any out-of-order or overlapping event
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q | (alu_start & !start_ok) | multi | (out_en1 & state_q != WAIT_P1)
            | (out_en2 & state_q != WAIT_P2) | (alu_rdy & state_q != WAIT_RDY);
    unique case (state_q)
      IDLE: if (alu_start && start_ok) begin
        state_d = WAIT_P1;
        addr_d  = dest_addr;
      end
      WAIT_P1: if (out_en1 && !multi) begin
        state_d = WAIT_P2;
        lo_d    = lane_result;
      end
      WAIT_P2: if (out_en2 && !multi) begin
        state_d = WAIT_RDY;
        hi_d    = lane_result;
      end
      WAIT_RDY: if (push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State, capture registers and circular writeback FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        maddr_q[i] <= '0;
        mdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      if (push) begin
        maddr_q[wr_q] <= addr_q;
        mdata_q[wr_q] <= {hi_q, lo_q};
        wr_q          <= inc(wr_q);
      end
      if (pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed and random checks of the result collector against a queue-based model
module tb_alu_result_collector;
  localparam int LW = 8, AW = 4, D = 2;
  logic          clk = 1'b0;
  logic          reset = 1'b1, alu_start = 1'b0, out_en1 = 1'b0, out_en2 = 1'b0, alu_rdy = 1'b0, wb_ready = 1'b0;
  logic [AW-1:0] dest_addr = '0;
  logic [31:0]   lane_result = '0;
  logic          start_ok, wb_valid, seq_err;
  logic [AW-1:0] wb_addr;
  logic [63:0]   wb_data;
  int            n_cmp = 0, n_bad = 0;
  int            stage = 0;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_lo, m_hi;
  logic          m_err = 1'b0;
  logic [AW+63:0] sb[$];

  alu_result_collector #(.LANE_W(LW), .REG_AW(AW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .alu_start(alu_start), .dest_addr(dest_addr),
    .out_en1(out_en1), .out_en2(out_en2), .alu_rdy(alu_rdy), .lane_result(lane_result),
    .start_ok(start_ok), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ready(wb_ready), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: the model decides from pre-edge state and inputs, then outputs are compared 1ns after the edge.
  task automatic cyc();
    bit ok, pp;
    int n;
    logic [AW+63:0] h;
    ok = stage == 0 && sb.size() < D;
    pp = sb.size() > 0 && wb_ready;
    n  = int'(out_en1) + int'(out_en2) + int'(alu_rdy);
    @(posedge clk);
    #1;
    if (reset) begin
      stage = 0;
      m_err = 1'b0;
      sb.delete();
    end else begin
      if ((alu_start && !ok) || n > 1 || (out_en1 && stage != 1) || (out_en2 && stage != 2) || (alu_rdy && stage != 3))
        m_err = 1'b1;
      if (pp) void'(sb.pop_front());
      if (n == 1) begin
        if (stage == 1 && out_en1) begin m_lo = lane_result; stage = 2; end
        else if (stage == 2 && out_en2) begin m_hi = lane_result; stage = 3; end
        else if (stage == 3 && alu_rdy) begin sb.push_back({m_addr, m_hi, m_lo}); stage = 0; end
      end
      if (alu_start && ok) begin m_addr = dest_addr; stage = 1; end
    end
    chk("start_ok", start_ok, stage == 0 && sb.size() < D);
    chk("wb_valid", wb_valid, sb.size() > 0);
    chk("seq_err", seq_err, m_err);
    if (sb.size() > 0) begin
      h = sb[0];
      chk("wb_addr", wb_addr, h[AW+63:64]);
      chk("wb_data", wb_data, h[63:0]);
    end
  endtask

  task automatic idle_in();
    alu_start = 1'b0; out_en1 = 1'b0; out_en2 = 1'b0; alu_rdy = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic op(input logic [AW-1:0] a, input logic [31:0] lo, input logic [31:0] hi, input bit rdy_last);
    idle_in();
    alu_start = 1'b1; dest_addr = a; cyc();
    alu_start = 1'b0; out_en1 = 1'b1; lane_result = lo; cyc();
    out_en1 = 1'b0; out_en2 = 1'b1; lane_result = hi; cyc();
    out_en2 = 1'b0; alu_rdy = 1'b1;
    if (rdy_last) wb_ready = 1'b1;
    cyc();
    alu_rdy = 1'b0;
  endtask

  task automatic rand_run(input int cycles, input int junk);
    for (int i = 0; i < cycles; i++) begin
      wb_ready    = ($urandom % 4) != 0;
      dest_addr   = AW'($urandom);
      lane_result = $urandom;
      alu_start   = (stage == 0 && ($urandom % 2) == 1) || (junk > 0 && ($urandom % junk) == 0);
      out_en1     = stage == 1 || (junk > 0 && ($urandom % junk) == 0);
      out_en2     = stage == 2 || (junk > 0 && ($urandom % junk) == 0);
      alu_rdy     = (stage == 3 && ($urandom % 3) != 0) || (junk > 0 && ($urandom % junk) == 0);
      cyc();
    end
    idle_in();
  endtask

  initial begin
    do_reset();
    chk("rst_start_ok", start_ok, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_addr", wb_addr, '0);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_seq_err", seq_err, 1'b0);
    wb_ready = 1'b1;
    op(4'd5, 32'h44332211, 32'h88776655, 1'b0);
    chk("single_valid", wb_valid, 1'b1);
    chk("single_addr", wb_addr, 4'd5);
    chk("single_data", wb_data, 64'h8877665544332211);
    chk("single_start_ok", start_ok, 1'b1);
    idle_in();
    cyc();
    chk("single_empty", wb_valid, 1'b0);
    chk("single_err", seq_err, 1'b0);
    wb_ready = 1'b0;
    op(4'd1, 32'hA1A2A3A4, 32'hB1B2B3B4, 1'b0);
    op(4'd2, 32'hC1C2C3C4, 32'hD1D2D3D4, 1'b0);
    chk("bp_start_ok", start_ok, 1'b0);
    alu_start = 1'b1; dest_addr = 4'd7; cyc(); alu_start = 1'b0;
    chk("bp_drop_err", seq_err, 1'b1);
    cyc();
    cyc();
    chk("bp_hold_addr", wb_addr, 4'd1);
    chk("bp_hold_data", wb_data, 64'hB1B2B3B4A1A2A3A4);
    wb_ready = 1'b1;
    cyc();
    chk("bp_second_addr", wb_addr, 4'd2);
    chk("bp_second_valid", wb_valid, 1'b1);
    cyc();
    chk("bp_drained", wb_valid, 1'b0);
    do_reset();
    wb_ready = 1'b0;
    op(4'd3, 32'h01020304, 32'h05060708, 1'b0);
    op(4'd4, 32'h11121314, 32'h15161718, 1'b1);
    chk("pp_valid", wb_valid, 1'b1);
    chk("pp_addr", wb_addr, 4'd4);
    chk("pp_data", wb_data, 64'h1516171811121314);
    chk("pp_start_ok", start_ok, 1'b1);
    wb_ready = 1'b0;
    do_reset();
    alu_start = 1'b1; dest_addr = 4'd6; cyc(); alu_start = 1'b0;
    out_en2 = 1'b1; lane_result = 32'hDEADBEEF; cyc(); out_en2 = 1'b0;
    chk("perr_en2_flag", seq_err, 1'b1);
    out_en1 = 1'b1; lane_result = 32'h76543210; cyc(); out_en1 = 1'b0;
    out_en2 = 1'b1; lane_result = 32'hFEDCBA98; cyc(); out_en2 = 1'b0;
    alu_rdy = 1'b1; cyc(); alu_rdy = 1'b0;
    chk("perr_stay_addr", wb_addr, 4'd6);
    chk("perr_stay_data", wb_data, 64'hFEDCBA9876543210);
    do_reset();
    wb_ready = 1'b1;
    out_en1 = 1'b1; lane_result = 32'hCAFEF00D; cyc(); out_en1 = 1'b0;
    chk("perr_idle_en1", seq_err, 1'b1);
    chk("perr_idle_start_ok", start_ok, 1'b1);
    op(4'd8, 32'h13572468, 32'h24681357, 1'b0);
    chk("perr_after_data", wb_data, 64'h2468135713572468);
    do_reset();
    alu_start = 1'b1; cyc(); alu_start = 1'b0;
    out_en1 = 1'b1; cyc(); out_en1 = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("mid_rst_start_ok", start_ok, 1'b1);
    chk("mid_rst_valid", wb_valid, 1'b0);
    chk("mid_rst_err", seq_err, 1'b0);
    alu_rdy = 1'b1; cyc(); alu_rdy = 1'b0;
    chk("mid_rst_rdy_err", seq_err, 1'b1);
    chk("mid_rst_no_push", wb_valid, 1'b0);
    do_reset();
    rand_run(400, 0);
    do_reset();
    rand_run(300, 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream companion of the four-lane ALU control FSM. It captures the two half-vector results the four-lane ALU produces in its two phases (phase 1 = lanes 0-3, phase 2 = lanes 4-7) and assembles them into one 8-lane vector. When the ALU signals ready, it pushes the vector and its destination register address into a small writeback FIFO. The FIFO drains to the vector register file through a valid/ready handshake. `start_ok` back-pressures the issue logic so a completed result never finds the FIFO full.

## Interface
Parameters:
- `LANE_W`, 8, width of one lane element in bits
- `REG_AW`, 4, vector register address width
- `DEPTH`, 2, writeback FIFO entries (≥1)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `alu_start`  in  1  same pulse that starts the ALU control FSM
- `dest_addr`  in  REG_AW  destination vector register, sampled with an accepted `alu_start`
- `out_en1`  in  1  phase-1 strobe: `lane_result` holds lanes 0-3
- `out_en2`  in  1  phase-2 strobe: `lane_result` holds lanes 4-7
- `alu_rdy`  in  1  ALU operation complete
- `lane_result`  in  4*LANE_W  four-lane ALU output, lane 0 in the LSBs
- `start_ok`  out  1  combinational; high when a new `alu_start` will be accepted
- `wb_valid`  out  1  FIFO head valid
- `wb_addr`  out  REG_AW  FIFO head destination register
- `wb_data`  out  8*LANE_W  FIFO head vector; lanes 0-3 in `[4*LANE_W-1:0]`, lanes 4-7 above
- `wb_ready`  in  1  register file accepts the head this cycle
- `seq_err`  out  1  sticky protocol-violation flag; cleared only by `reset`

## Operation
- FSM states: IDLE, WAIT_P1, WAIT_P2, WAIT_RDY.
  - IDLE → WAIT_P1 on `alu_start & start_ok`. `dest_addr` is captured on the same edge.
  - WAIT_P1 → WAIT_P2 on `out_en1`. `lane_result` is captured into the low half.
  - WAIT_P2 → WAIT_RDY on `out_en2`. `lane_result` is captured into the high half.
  - WAIT_RDY → IDLE on `alu_rdy`. `{addr, high, low}` is pushed into the FIFO.
- `start_ok = (state == IDLE) && (count < DEPTH)`.
  - The in-flight op reserves a slot, so a push never meets a full FIFO.
- Pop occurs when `wb_valid & wb_ready`. A simultaneous push and pop leaves `count` unchanged.
- `wb_ready` while `wb_valid` is low has no effect.
- The FIFO is circular: read and write pointers wrap modulo DEPTH, and `count` ranges 0..DEPTH.
- `seq_err` is set, and the offending event is otherwise ignored, in each of these cases:
  - `alu_start` while `start_ok` is low; the op is dropped and the FSM stays put.
  - `out_en1` in any state other than WAIT_P1.
  - `out_en2` in any state other than WAIT_P2.
  - `alu_rdy` in any state other than WAIT_RDY.
  - More than one of `out_en1`/`out_en2`/`alu_rdy` high in the same cycle.
- A dropped op produces later strobes in IDLE. Each of those strobes also sets `seq_err` and is ignored.
- No data transformation: results are bit-exact copies of `lane_result`.

## Timing
- Reset values:
  - state = IDLE; `count`, pointers = 0
  - `wb_valid` = 0, `seq_err` = 0
  - `start_ok` = 1 (after reset deasserts)
  - `wb_addr`/`wb_data` = 0
  - capture registers = 0
- Reset asserted mid-operation aborts the op; no partial entry is ever pushed.
- Nominal sequence with the control FSM:
  - cycle 0: `alu_start`
  - cycle 1: `out_en1`
  - cycle 2: `out_en2`
  - cycle 3: `alu_rdy`
  - cycle 4: `wb_valid` = 1 (push latency 1 cycle after `alu_rdy`)
- `start_ok` is low from cycle 1 until the FSM returns to IDLE, and additionally whenever `count == DEPTH`.
- The earliest next accepted `alu_start` is cycle 4.
- `wb_valid`, `wb_addr` and `wb_data` are registered. They are stable while `wb_valid & !wb_ready`.
- After a pop the next entry appears the following cycle. There is no bubble when the FIFO holds ≥2 entries.
- Throughput: one result per 4 cycles, limited by the ALU.

## Test plan
- Single op: `dest_addr`=5; `lane_result`=0x44332211 at `out_en1`, 0x88776655 at `out_en2`; `wb_ready`=1 → cycle 4 shows `wb_valid`=1, `wb_addr`=5, `wb_data`=0x8877665544332211; FIFO is empty in cycle 5; `seq_err`=0.
- Back-pressure: `wb_ready`=0; two ops to regs 1 and 2 complete → `count`=2, `start_ok`=0. A third `alu_start` sets `seq_err`=1 and is dropped. Raise `wb_ready` → reg 1 drains, then reg 2 on consecutive cycles, head held stable while stalled.
- Simultaneous push/pop: `count`=1 and `wb_ready`=1 in the same cycle as `alu_rdy` → `count` stays 1 and the new entry becomes head next cycle.
- Protocol errors: `out_en2` in WAIT_P1 → `seq_err`=1, FSM stays in WAIT_P1. `out_en1` in IDLE → `seq_err`=1, no capture.
- Reset mid-op: assert `reset` in WAIT_P2 → next cycle state=IDLE, `wb_valid`=0, `start_ok`=1, `seq_err`=0; a later `alu_rdy` in IDLE flags `seq_err` and pushes nothing.
- Wrap-around: DEPTH=2, six ops with random `wb_ready` → outputs match a scoreboard in order, no loss or duplication.
